mcycle_unit: RTL and testbench

MCYCLE_UNIT -- requirements
Module: mcycle_unit

---
 rtl/mcycle_pkg.sv | 13 +
 rtl/mcycle_signfix.sv | 12 +
 rtl/mcycle_unit.sv | 147 ++++++++++++++
 tb/tb_mcycle_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_signfix.sv
// Conditional two's-complement negation; yields magnitude when neg is the sign bit.
module mcycle_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multi-cycle multiply/divide unit: shift-add multiply, restoring divide,
// one shared 2*WIDTH shift register and one WIDTH+1 adder.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);
  import mcycle_pkg::*;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = 2 * WIDTH;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_q;
  logic               neg_q;
  logic               neg_r;
  logic               dz_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [DW-1:0]      sr;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept, last;
  logic [WIDTH:0]     add_a, add_b, sum;
  logic               qbit;
  logic [DW-1:0]      sr_step;
  logic [DW-1:0]      prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res1_n, res2_n;

  assign a_neg = Signed & Operand1[WIDTH-1];
  assign b_neg = Signed & Operand2[WIDTH-1];

  mcycle_signfix #(.W(WIDTH)) u_fix_a (.value(Operand1), .neg(a_neg), .result(mag_a));
  mcycle_signfix #(.W(WIDTH)) u_fix_b (.value(Operand2), .neg(b_neg), .result(mag_b));

  assign accept = Start & ~Flush & (state != COMPUTE);
  assign last   = (state == COMPUTE) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    Busy = (Start & ~Flush & ((state == IDLE) || (state == DONE))) | (state == COMPUTE);
  end

  // Shared adder: accumulate multiplicand, or trial-subtract divisor from shifted remainder
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    sum     = '0;
    qbit    = 1'b0;
    sr_step = sr;
    if (op_q == OP_MUL) begin
      add_a   = {1'b0, sr[DW-1:WIDTH]};
      add_b   = {1'b0, opnd_q};
      sum     = add_a + add_b;
      sr_step = sr[0] ? {sum, sr[WIDTH-1:1]} : {add_a, sr[WIDTH-1:1]};
    end else begin
      add_a   = sr[DW-1:WIDTH-1];
      add_b   = ~{1'b0, opnd_q};
      sum     = add_a + add_b + (WIDTH+1)'(1);
      qbit    = ~sum[WIDTH];
      sr_step = qbit ? {sum[WIDTH-1:0], sr[WIDTH-2:0], 1'b1}
                     : {add_a[WIDTH-1:0], sr[WIDTH-2:0], 1'b0};
    end
  end

  mcycle_signfix #(.W(DW))    u_fix_p (.value(sr_step), .neg(neg_q), .result(prod));
  mcycle_signfix #(.W(WIDTH)) u_fix_q (.value(sr_step[WIDTH-1:0]), .neg(neg_q), .result(quot));
  mcycle_signfix #(.W(WIDTH)) u_fix_r (.value(sr_step[DW-1:WIDTH]), .neg(neg_r), .result(rem));

  // Divide by zero: magnitude remainder re-signed by the dividend sign is Operand1 itself
  always_comb begin
    res1_n = prod[WIDTH-1:0];
    res2_n = prod[DW-1:WIDTH];
    if (op_q == OP_DIV) begin
      res1_n = dz_q ? {WIDTH{1'b1}} : quot;
      res2_n = rem;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      sr      <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= COMPUTE;
            cnt    <= '0;
            op_q   <= MCycleOp;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz_q   <= (Operand2 == '0);
            opnd_q <= (MCycleOp == OP_MUL) ? mag_a : mag_b;
            sr     <= {WIDTH'(0), ((MCycleOp == OP_MUL) ? mag_b : mag_a)};
          end else begin
            state <= IDLE;
          end
        end
        COMPUTE: begin
          if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            sr  <= sr_step;
            cnt <= cnt + CW'(1);
            if (last) begin
              state   <= DONE;
              cnt     <= '0;
              Done    <= 1'b1;
              DivZero <= (op_q == OP_DIV) & dz_q;
              Result1 <= res1_n;
              Result2 <= res2_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: directed operations, flush/reset aborts, back-to-back.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             CLK = 1'b0;
  logic             Reset, Start, MCycleOp, Signed, Flush;
  logic [WIDTH-1:0] Operand1, Operand2, Result1, Result2;
  logic             Busy, Done, DivZero;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             dz;
    int unsigned      cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp), .Signed(Signed),
    .Flush(Flush), .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1),
    .Result2(Result2), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation
  always @(negedge CLK) begin
    exp_t e;
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(Done), 64'(0));
      end else begin
        e = sb.pop_front();
        chk({e.name, ".r1"}, 64'(Result1), 64'(e.r1));
        chk({e.name, ".r2"}, 64'(Result2), 64'(e.r2));
        chk({e.name, ".divzero"}, 64'(DivZero), 64'(e.dz));
        chk({e.name, ".latency"}, 64'(cyc - e.cyc), 64'(WIDTH));
      end
    end else if (!Reset && DivZero) begin
      chk("divzero_without_done", 64'(DivZero), 64'(0));
    end
  end

  task automatic launch(input logic op, input logic sgn, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Signed = sgn; Operand1 = a; Operand2 = b;
    @(posedge CLK); #1;
    Start = 1'b0; Operand1 = '1; Operand2 = '1; MCycleOp = ~op; Signed = ~sgn;
  endtask

  task automatic push(input string name, input logic [WIDTH-1:0] r1,
                      input logic [WIDTH-1:0] r2, input logic dz);
    exp_t e;
    e.name = name; e.r1 = r1; e.r2 = r2; e.dz = dz; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < int'(WIDTH) + 8) begin
      @(negedge CLK); #2;
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, ".timeout_pending"}, 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  task automatic run_op(input string name, input logic op, input logic sgn,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                        input logic dz);
    launch(op, sgn, a, b);
    push(name, r1, r2, dz);
    wait_empty(name);
  endtask

  task automatic watch_no_done(input string name, input int ncyc);
    logic seen = 1'b0;
    repeat (ncyc) begin
      @(negedge CLK);
      if (Done) seen = 1'b1;
    end
    chk({name, ".no_done"}, 64'(seen), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    Reset = 1'b1; Start = 1'b0; MCycleOp = OP_MUL; Signed = 1'b0; Flush = 1'b0;
    Operand1 = '0; Operand2 = '0;
    #12;
    chk("reset.r1", 64'(Result1), 64'(0));
    chk("reset.r2", 64'(Result2), 64'(0));
    chk("reset.done", 64'(Done), 64'(0));
    chk("reset.divzero", 64'(DivZero), 64'(0));
    chk("reset.busy", 64'(Busy), 64'(0));
    Start = 1'b1; #1;
    chk("reset.busy_start", 64'(Busy), 64'(1));
    Start = 1'b0;
    @(negedge CLK); Reset = 1'b0;

    // 7 x 6 with Busy held through COMPUTE and dropped in DONE
    launch(OP_MUL, 1'b0, 32'd7, 32'd6);
    push("mul_7x6", 32'd42, 32'd0, 1'b0);
    for (int i = 0; i < int'(WIDTH); i++) begin
      @(negedge CLK);
      chk($sformatf("mul_7x6.busy_c%0d", i), 64'(Busy), 64'(1));
    end
    wait_empty("mul_7x6");
    chk("mul_7x6.busy_in_done", 64'(Busy), 64'(0));

    run_op("mul_s_m3x5", OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_u_max", OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mul_s_m1xm1", OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    run_op("div_u_100_7", OP_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("div_s_m7_2", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("div_s_7_m2", OP_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("div_u_big", OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0);
    run_op("div_5_0", OP_DIV, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("div_s_m5_0", OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    run_op("div_s_ovf", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);

    // Start pulsed mid-COMPUTE must be ignored
    launch(OP_MUL, 1'b0, 32'd3, 32'd4);
    push("start_in_compute", 32'd12, 32'd0, 1'b0);
    repeat (6) @(negedge CLK);
    Start = 1'b1; MCycleOp = OP_DIV; Operand1 = 32'd100; Operand2 = 32'd100;
    @(negedge CLK); Start = 1'b0;
    wait_empty("start_in_compute");
    watch_no_done("start_in_compute", int'(WIDTH) + 4);

    // Flush at COMPUTE cycle 10: no Done, previous results kept
    launch(OP_MUL, 1'b0, 32'd9, 32'd9);
    repeat (11) @(negedge CLK);
    Flush = 1'b1;
    @(posedge CLK); #1; Flush = 1'b0;
    @(negedge CLK);
    chk("flush.busy", 64'(Busy), 64'(0));
    chk("flush.done", 64'(Done), 64'(0));
    chk("flush.r1_held", 64'(Result1), 64'(12));
    chk("flush.r2_held", 64'(Result2), 64'(0));
    watch_no_done("flush", int'(WIDTH) + 4);

    // Flush together with Start in IDLE suppresses acceptance
    @(negedge CLK);
    Start = 1'b1; Flush = 1'b1; MCycleOp = OP_MUL; Signed = 1'b0; Operand1 = 32'd2; Operand2 = 32'd2;
    #1 chk("flush_start.busy", 64'(Busy), 64'(0));
    @(posedge CLK); #1; Start = 1'b0; Flush = 1'b0;
    watch_no_done("flush_start", int'(WIDTH) + 4);
    chk("flush_start.r1_held", 64'(Result1), 64'(12));

    // Reset at COMPUTE cycle 10 aborts and clears everything
    launch(OP_DIV, 1'b0, 32'd50, 32'd3);
    repeat (11) @(negedge CLK);
    Reset = 1'b1; #1;
    chk("rst_mid.r1", 64'(Result1), 64'(0));
    chk("rst_mid.r2", 64'(Result2), 64'(0));
    chk("rst_mid.done", 64'(Done), 64'(0));
    chk("rst_mid.divzero", 64'(DivZero), 64'(0));
    chk("rst_mid.busy", 64'(Busy), 64'(0));
    @(negedge CLK); Reset = 1'b0;
    watch_no_done("rst_mid", int'(WIDTH) + 4);

    // Back-to-back: Start accepted in the DONE cycle
    launch(OP_MUL, 1'b0, 32'd7, 32'd6);
    push("b2b_first", 32'd42, 32'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < int'(WIDTH) + 8; i++) begin
      @(negedge CLK);
      if (Done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b.first_done_seen", 64'(seen), 64'(1));
    Start = 1'b1; MCycleOp = OP_DIV; Signed = 1'b0; Operand1 = 32'd100; Operand2 = 32'd7;
    #1 chk("b2b.busy_in_done", 64'(Busy), 64'(1));
    @(posedge CLK); #1;
    Start = 1'b0;
    push("b2b_second", 32'd14, 32'd2, 1'b0);
    wait_empty("b2b_second");

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
